color_scan_arbiter: RTL and testbench

- Shares the single TCS3200 color detector between NUM_REQ requesters, e.g. per-player or per-slot game logic.
- Grants the detector round-robin and pulses its start input.
- Waits for completion, guarded by a timeout.
- Repeats scans until CONFIRM_COUNT consecutive identical colors are seen, then returns a confirmed color (or an error) to the granted requester.

---
 rtl/color_scan_arbiter.sv | 147 ++++++++++++++
 tb/tb_color_scan_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_scan_arbiter.sv
// rtl/color_scan_arbiter.sv - round-robin sharing of one color detector with repeated-scan confirmation
module color_scan_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int CONFIRM_COUNT  = 2,
   parameter int MAX_ATTEMPTS   = 6,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] ack,
   output logic               busy,
   output logic [2:0]         grant_id,
   output logic               start_detection,
   input  logic               detection_complete,
   input  logic [1:0]         detected_color,
   output logic               result_valid,
   output logic [1:0]         result_color,
   output logic               result_error,
   output logic [3:0]         attempts_used
);

   localparam int            IW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int            TW             = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TIMER_LAST     = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]    ATTEMPT_LIMIT  = 4'(MAX_ATTEMPTS);
   localparam logic [3:0]    CONFIRM_TARGET = 4'(CONFIRM_COUNT);

   typedef enum logic [2:0] {IDLE, START, WAIT_DONE, EVALUATE, REPORT} stateT;

   stateT         state;
   logic [2:0]    lastGrant;
   logic [2:0]    pickId;
   logic          pickFound;
   logic [3:0]    cand;
   logic [3:0]    matchCount;
   logic [3:0]    evalMatch;
   logic [3:0]    attempts;
   logic [TW-1:0] timer;
   logic [1:0]    prevColor;
   logic [1:0]    curColor;

   // Search upward from the requester after the last one served, wrapping.
   always_comb begin
      pickId    = '0;
      pickFound = 1'b0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, lastGrant} + 4'(k);
         if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
         if (!pickFound && req[cand[IW-1:0]]) begin
            pickFound = 1'b1;
            pickId    = cand[2:0];
         end
      end
   end

   always_comb begin
      evalMatch = 4'd1;
      if (matchCount != 4'd0 && curColor == prevColor) evalMatch = matchCount + 4'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         lastGrant       <= 3'(NUM_REQ - 1);
         grant_id        <= '0;
         matchCount      <= '0;
         attempts        <= '0;
         timer           <= '0;
         prevColor       <= '0;
         curColor        <= '0;
         ack             <= '0;
         busy            <= 1'b0;
         start_detection <= 1'b0;
         result_valid    <= 1'b0;
         result_color    <= '0;
         result_error    <= 1'b0;
         attempts_used   <= '0;
      end else begin
         start_detection <= 1'b0;
         result_valid    <= 1'b0;
         ack             <= '0;
         case (state)
            IDLE: begin
               if (pickFound) begin
                  grant_id        <= pickId;
                  matchCount      <= '0;
                  attempts        <= '0;
                  prevColor       <= '0;
                  busy            <= 1'b1;
                  start_detection <= 1'b1;
                  state           <= START;
               end
            end
            START: begin
               attempts <= attempts + 4'd1;
               timer    <= '0;
               state    <= WAIT_DONE;
            end
            WAIT_DONE: begin
               // A completion on the final timeout cycle still counts as a result.
               if (detection_complete) begin
                  curColor <= detected_color;
                  state    <= EVALUATE;
               end else if (timer == TIMER_LAST) begin
                  if (attempts == ATTEMPT_LIMIT) begin
                     result_valid               <= 1'b1;
                     ack[grant_id[IW-1:0]]      <= 1'b1;
                     result_color               <= prevColor;
                     result_error               <= 1'b1;
                     attempts_used              <= attempts;
                     state                      <= REPORT;
                  end else begin
                     start_detection <= 1'b1;
                     state           <= START;
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            EVALUATE: begin
               matchCount <= evalMatch;
               prevColor  <= curColor;
               if (evalMatch == CONFIRM_TARGET || attempts == ATTEMPT_LIMIT) begin
                  result_valid          <= 1'b1;
                  ack[grant_id[IW-1:0]] <= 1'b1;
                  result_color          <= curColor;
                  result_error          <= (evalMatch != CONFIRM_TARGET);
                  attempts_used         <= attempts;
                  state                 <= REPORT;
               end else begin
                  start_detection <= 1'b1;
                  state           <= START;
               end
            end
            REPORT: begin
               lastGrant <= grant_id;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_color_scan_arbiter.sv
// tb/tb_color_scan_arbiter.sv - randomized self-checking bench for color_scan_arbiter
module tb_color_scan_arbiter;

   localparam int NREQ = 4;
   localparam int CONF = 2;
   localparam int MAXA = 6;
   localparam int TMO  = 16;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [NREQ-1:0] req = '0;
   logic            detection_complete = 1'b0;
   logic [1:0]      detected_color = 2'b00;
   logic [NREQ-1:0] ack;
   logic            busy;
   logic [2:0]      grant_id;
   logic            start_detection;
   logic            result_valid;
   logic [1:0]      result_color;
   logic            result_error;
   logic [3:0]      attempts_used;

   int         nCompared = 0;
   int         nMismatch = 0;
   int         planDelay[$];
   logic [1:0] planColor[$];
   int         pendingDue = -1;
   logic [1:0] pendingColor = 2'b00;
   int         cycle = 0;
   int         startCount = 0;
   int         lastStart = -100;
   int         spacingViolations = 0;
   int         ackCount = 0;
   bit         injectComplete = 1'b0;
   int         expLast = NREQ - 1;

   color_scan_arbiter #(
      .NUM_REQ(NREQ), .CONFIRM_COUNT(CONF), .MAX_ATTEMPTS(MAXA), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .ack(ack), .busy(busy), .grant_id(grant_id),
      .start_detection(start_detection), .detection_complete(detection_complete),
      .detected_color(detected_color), .result_valid(result_valid),
      .result_color(result_color), .result_error(result_error), .attempts_used(attempts_used)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

   // Detector model: answers each start pulse with the next planned (delay, color); delay 0 = silent.
   initial begin
      int d;
      logic [1:0] c;
      forever begin
         @(negedge clk);
         cycle++;
         detection_complete = 1'b0;
         if (injectComplete) begin
            detection_complete = 1'b1;
            detected_color     = 2'($urandom);
            injectComplete     = 1'b0;
         end
         if (pendingDue == cycle) begin
            detection_complete = 1'b1;
            detected_color     = pendingColor;
            pendingDue         = -1;
         end
         if (result_valid) ackCount++;
         if (start_detection) begin
            startCount++;
            if (cycle - lastStart < 3) spacingViolations++;
            lastStart = cycle;
            if (planDelay.size() > 0) begin
               d = planDelay.pop_front();
               c = planColor.pop_front();
               if (d > 0) begin
                  pendingDue   = cycle + d;
                  pendingColor = c;
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic flushPlan();
      planDelay.delete();
      planColor.delete();
      pendingDue = -1;
   endtask

   task automatic pushPlan(input int d, input logic [1:0] c);
      planDelay.push_back(d);
      planColor.push_back(c);
   endtask

   task automatic doReset();
      reset = 1'b0;
      req   = '0;
      flushPlan();
      tick();
      reset   = 1'b1;
      expLast = NREQ - 1;
   endtask

   function automatic int expectedGrant(input logic [NREQ-1:0] r);
      int idx;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (expLast + k) % NREQ;
         if (r[idx[1:0]]) return idx;
      end
      return -1;
   endfunction

   // Outcome of a grant: success once the last CONF answered scans agree; error after MAXA starts.
   task automatic modelPlan(output logic [1:0] c, output logic e, output int a);
      logic [1:0] seen[$];
      bit same;
      c = 2'b00;
      e = 1'b1;
      a = MAXA;
      for (int i = 0; i < MAXA; i++) begin
         if (i < planDelay.size() && planDelay[i] > 0) begin
            seen.push_back(planColor[i]);
            if (seen.size() >= CONF) begin
               same = 1'b1;
               for (int j = 1; j < CONF; j++)
                  if (seen[seen.size()-1-j] != seen[seen.size()-1]) same = 1'b0;
               if (same) begin
                  c = seen[seen.size()-1];
                  e = 1'b0;
                  a = i + 1;
                  break;
               end
            end
         end
      end
      if (e) c = (seen.size() > 0) ? seen[seen.size()-1] : 2'b00;
      while (planDelay.size() > a) begin
         void'(planDelay.pop_back());
         void'(planColor.pop_back());
      end
   endtask

   task automatic runGrant(input logic [NREQ-1:0] r, input int dropAfter, output bit got, output int starts);
      int s0;
      s0  = startCount;
      req = r;
      got = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
         tick();
         if (dropAfter > 0 && i == dropAfter) req = '0;
         if (result_valid) got = 1'b1;
      end
      starts = startCount - s0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      nCompared++;
      if ({ack, busy, grant_id, start_detection, result_valid, result_color, result_error, attempts_used} !== 17'h0) begin
         nMismatch++;
         $display("FAIL reset_outputs: got %h expected 0", {ack, busy, grant_id, start_detection, result_valid, result_color, result_error, attempts_used});
      end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      nCompared++;
      if (busy !== 1'b0 || startCount !== 0) begin
         nMismatch++;
         $display("FAIL idle_quiet: busy=%b starts=%0d expected busy=0 starts=0", busy, startCount);
      end
   endtask

   task automatic test_single();
      bit got;
      int starts;
      flushPlan();
      pushPlan(10, 2'b01);
      pushPlan(10, 2'b01);
      runGrant(4'b0001, 0, got, starts);
      req = '0;
      nCompared++;
      if (!got || grant_id !== 3'd0 || ack !== 4'b0001) begin
         nMismatch++;
         $display("FAIL single_grant: valid=%b id=%0d ack=%b expected valid=1 id=0 ack=0001", got, grant_id, ack);
      end
      nCompared++;
      if ({result_color, result_error, attempts_used} !== {2'b01, 1'b0, 4'd2}) begin
         nMismatch++;
         $display("FAIL single_result: color=%b err=%b att=%0d expected color=01 err=0 att=2", result_color, result_error, attempts_used);
      end
      nCompared++;
      if (starts !== 2) begin
         nMismatch++;
         $display("FAIL single_starts: got %0d expected 2", starts);
      end
      expLast = 0;
   endtask

   task automatic test_round_robin();
      bit got;
      int starts;
      logic [1:0] rc;
      doReset();
      for (int g = 0; g < 5; g++) begin
         rc = 2'($urandom_range(0, 3));
         pushPlan($urandom_range(1, TMO - 1), rc);
         pushPlan($urandom_range(1, TMO - 1), rc);
         runGrant(4'b1111, 0, got, starts);
         nCompared++;
         if (!got || grant_id !== 3'(g % 4) || ack !== 4'(1 << (g % 4))) begin
            nMismatch++;
            $display("FAIL rr_grant%0d: valid=%b id=%0d ack=%b expected id=%0d ack=%b", g, got, grant_id, ack, g % 4, 4'(1 << (g % 4)));
         end
         nCompared++;
         if ({result_color, result_error, attempts_used, 4'(starts)} !== {rc, 1'b0, 4'd2, 4'd2}) begin
            nMismatch++;
            $display("FAIL rr_result%0d: color=%b err=%b att=%0d starts=%0d expected color=%b err=0 att=2 starts=2", g, result_color, result_error, attempts_used, starts, rc);
         end
      end
      req     = '0;
      expLast = 0;
   endtask

   task automatic test_alternating();
      bit got;
      int starts;
      flushPlan();
      for (int i = 0; i < MAXA; i++) pushPlan($urandom_range(1, TMO - 1), (i % 2 == 0) ? 2'b00 : 2'b10);
      runGrant(4'b0010, 5, got, starts);
      req = '0;
      nCompared++;
      if (!got || grant_id !== 3'd1 || ack !== 4'b0010) begin
         nMismatch++;
         $display("FAIL alt_grant: valid=%b id=%0d ack=%b expected valid=1 id=1 ack=0010", got, grant_id, ack);
      end
      nCompared++;
      if ({result_color, result_error, attempts_used, 4'(starts)} !== {2'b10, 1'b1, 4'd6, 4'd6}) begin
         nMismatch++;
         $display("FAIL alt_result: color=%b err=%b att=%0d starts=%0d expected color=10 err=1 att=6 starts=6", result_color, result_error, attempts_used, starts);
      end
      expLast = 1;
   endtask

   task automatic test_no_response();
      bit got;
      int starts;
      doReset();
      for (int i = 0; i < MAXA; i++) pushPlan(0, 2'b11);
      runGrant(4'b0100, 0, got, starts);
      req = '0;
      nCompared++;
      if (!got || grant_id !== 3'd2 || ack !== 4'b0100) begin
         nMismatch++;
         $display("FAIL noresp_grant: valid=%b id=%0d ack=%b expected valid=1 id=2 ack=0100", got, grant_id, ack);
      end
      nCompared++;
      if ({result_color, result_error, attempts_used, 4'(starts)} !== {2'b00, 1'b1, 4'd6, 4'd6}) begin
         nMismatch++;
         $display("FAIL noresp_result: color=%b err=%b att=%0d starts=%0d expected color=00 err=1 att=6 starts=6", result_color, result_error, attempts_used, starts);
      end
      expLast = 2;
   endtask

   task automatic test_timeout_race();
      bit got;
      int starts;
      flushPlan();
      pushPlan(TMO, 2'b11);
      pushPlan(TMO, 2'b11);
      runGrant(4'b1000, 0, got, starts);
      req = '0;
      nCompared++;
      if (!got || grant_id !== 3'd3 || {result_color, result_error, attempts_used, 4'(starts)} !== {2'b11, 1'b0, 4'd2, 4'd2}) begin
         nMismatch++;
         $display("FAIL race_result: valid=%b id=%0d color=%b err=%b att=%0d starts=%0d expected id=3 color=11 err=0 att=2 starts=2", got, grant_id, result_color, result_error, attempts_used, starts);
      end
      expLast = 3;
   endtask

   task automatic test_random();
      bit got;
      int starts, expId, ea;
      logic [1:0] ec;
      logic ee;
      logic [NREQ-1:0] r;
      for (int g = 0; g < 25; g++) begin
         r = 4'($urandom_range(1, 15));
         expId = expectedGrant(r);
         flushPlan();
         for (int i = 0; i < MAXA; i++)
            pushPlan(($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TMO)), 2'($urandom_range(0, 2)));
         modelPlan(ec, ee, ea);
         runGrant(r, 0, got, starts);
         nCompared++;
         if (!got || grant_id !== 3'(expId) || ack !== 4'(1 << expId)) begin
            nMismatch++;
            $display("FAIL rand_grant%0d: valid=%b id=%0d ack=%b expected id=%0d ack=%b", g, got, grant_id, ack, expId, 4'(1 << expId));
         end
         nCompared++;
         if ({result_color, result_error, attempts_used, 4'(starts)} !== {ec, ee, 4'(ea), 4'(ea)}) begin
            nMismatch++;
            $display("FAIL rand_result%0d: color=%b err=%b att=%0d starts=%0d expected color=%b err=%b att=%0d starts=%0d", g, result_color, result_error, attempts_used, starts, ec, ee, ea, ea);
         end
         expLast = expId;
      end
      req = '0;
      tick();
   endtask

   task automatic test_reset_mid_scan();
      bit got;
      int starts, s0, a0;
      flushPlan();
      pushPlan(0, 2'b00);
      s0  = startCount;
      req = 4'b0001;
      for (int i = 0; i < 20 && startCount == s0; i++) tick();
      for (int i = 0; i < 3; i++) tick();
      a0    = ackCount;
      reset = 1'b0;
      #1;
      nCompared++;
      if ({ack, busy, grant_id, start_detection, result_valid, result_color, result_error, attempts_used} !== 17'h0 || startCount == s0) begin
         nMismatch++;
         $display("FAIL midscan_reset_outputs: got %h starts=%0d expected 0 with a scan started", {ack, busy, grant_id, start_detection, result_valid, result_color, result_error, attempts_used}, startCount - s0);
      end
      tick();
      reset = 1'b1;
      req   = '0;
      flushPlan();
      expLast = NREQ - 1;
      s0 = startCount;
      injectComplete = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      nCompared++;
      if (busy !== 1'b0 || startCount !== s0 || ackCount !== a0) begin
         nMismatch++;
         $display("FAIL midscan_quiet: busy=%b new_starts=%0d new_acks=%0d expected 0 0 0", busy, startCount - s0, ackCount - a0);
      end
      pushPlan(5, 2'b11);
      pushPlan(5, 2'b11);
      runGrant(4'b0100, 0, got, starts);
      req = '0;
      nCompared++;
      if (!got || grant_id !== 3'd2 || ack !== 4'b0100 || {result_color, result_error, attempts_used, 4'(starts)} !== {2'b11, 1'b0, 4'd2, 4'd2}) begin
         nMismatch++;
         $display("FAIL midscan_regrant: valid=%b id=%0d ack=%b color=%b err=%b att=%0d starts=%0d expected id=2 ack=0100 color=11 err=0 att=2 starts=2", got, grant_id, ack, result_color, result_error, attempts_used, starts);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_alternating();
      test_no_response();
      test_timeout_race();
      test_random();
      test_reset_mid_scan();
      nCompared++;
      if (spacingViolations !== 0) begin
         nMismatch++;
         $display("FAIL start_spacing: got %0d close pulses expected 0", spacingViolations);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
